// File: rtl/exec_seq_pkg.sv
// Shared types and instruction-field layout for the instruction sequencer.
// The field positions here are the single source of truth for the decoder.
package exec_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_e;

  localparam logic [6:0] HALT_OPCODE = 7'b1111111;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNC_LSB   = 12;
  localparam int FUNC_MSB   = 15;
  localparam int RS1_LSB    = 16;
  localparam int RS1_MSB    = 20;
  localparam int RS2_LSB    = 21;
  localparam int RS2_MSB    = 25;
  localparam int IMM_LSB    = 26;
  localparam int IMM_MSB    = 31;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

endpackage

// File: rtl/exec_seq_decode.sv
// Purely combinational field extraction from the latched instruction word.
// The 6-bit immediate is sign-extended to 32 bits.
module exec_seq_decode
  import exec_seq_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [3:0]  func_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o
);

  assign opcode_o = instr_i[OPCODE_MSB:OPCODE_LSB];
  assign rd_o     = instr_i[RD_MSB:RD_LSB];
  assign func_o   = instr_i[FUNC_MSB:FUNC_LSB];
  assign rs1_o    = instr_i[RS1_MSB:RS1_LSB];
  assign rs2_o    = instr_i[RS2_MSB:RS2_LSB];
  assign imm_o    = {{(32 - IMM_W){instr_i[IMM_MSB]}}, instr_i[IMM_MSB:IMM_LSB]};

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving an external
// execute unit and register file. Handshake: imem_data is taken on any FETCH cycle with imem_valid=1.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic [6:0]  ex_opcode,
  output logic [3:0]  ex_func,
  output logic [31:0] ex_imm,
  input  logic [31:0] ex_sonuc,
  input  logic        ex_pc_update,
  input  logic        ex_we,
  input  logic        ex_hata,
  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        hata,
  output logic [15:0] instr_count
);

  localparam int TCNT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(FETCH_TIMEOUT - 1);

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        instr_q;
  logic [TCNT_W-1:0]  tcnt_q;
  logic [15:0]        instr_count_q;
  logic [6:0]         ex_opcode_q;
  logic [3:0]         ex_func_q;
  logic [31:0]        ex_imm_q;
  logic [4:0]         rs1_q;
  logic [4:0]         rs2_q;
  logic [4:0]         rd_q;
  logic [31:0]        sonuc_q;
  logic               pc_upd_q;
  logic               rf_we_q;

  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd;
  logic [3:0]  dec_func;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic [31:0] pc_d;

  exec_seq_decode u_decode (
    .instr_i  (instr_q),
    .opcode_o (dec_opcode),
    .rd_o     (dec_rd),
    .func_o   (dec_func),
    .rs1_o    (dec_rs1),
    .rs2_o    (dec_rs2),
    .imm_o    (dec_imm)
  );

  // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
  assign pc_d = pc_upd_q ? sonuc_q : (pc_q + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      tcnt_q        <= '0;
      instr_count_q <= '0;
      ex_opcode_q   <= '0;
      ex_func_q     <= '0;
      ex_imm_q      <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      sonuc_q       <= '0;
      pc_upd_q      <= 1'b0;
      rf_we_q       <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tcnt_q  <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            instr_q <= imem_data;
            state_q <= S_DECODE;
          end else if (tcnt_q == TCNT_LAST) begin
            state_q <= S_ERROR;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        S_DECODE: begin
          if (dec_opcode == HALT_OPCODE) begin
            state_q <= S_HALT;
          end else begin
            ex_opcode_q <= dec_opcode;
            ex_func_q   <= dec_func;
            ex_imm_q    <= dec_imm;
            rs1_q       <= dec_rs1;
            rs2_q       <= dec_rs2;
            rd_q        <= dec_rd;
            state_q     <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          sonuc_q  <= ex_sonuc;
          pc_upd_q <= ex_pc_update;
          // A taken branch to a non-word-aligned target is a fault, not a jump.
          if (ex_hata || (ex_pc_update && (ex_sonuc[1:0] != 2'b00))) begin
            state_q <= S_ERROR;
          end else begin
            rf_we_q <= ex_we && (rd_q != 5'd0);
            state_q <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          pc_q <= pc_d;
          if (instr_count_q != 16'hFFFF) begin
            instr_count_q <= instr_count_q + 16'd1;
          end
          tcnt_q  <= '0;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            pc_q    <= RESET_PC;
            tcnt_q  <= '0;
            state_q <= S_FETCH;
          end
        end
        S_ERROR: begin
          state_q <= S_ERROR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign halted      = (state_q == S_HALT);
  assign hata        = (state_q == S_ERROR);
  assign instr_count = instr_count_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_func     = ex_func_q;
  assign ex_imm      = ex_imm_q;
  assign rf_rs1_addr = rs1_q;
  assign rf_rs2_addr = rs2_q;
  assign rf_rd_addr  = rd_q;
  assign rf_wdata    = sonuc_q;
  assign rf_we       = rf_we_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed scenarios for exec_sequencer with a write scoreboard on the
// register-file port; a small instruction memory and a settable execute model.
module tb_exec_sequencer;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_NOP  = 7'b0010011;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [6:0]  ex_opcode;
  logic [3:0]  ex_func;
  logic [31:0] ex_imm;
  logic [31:0] ex_sonuc;
  logic        ex_pc_update;
  logic        ex_we;
  logic        ex_hata;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic        hata;
  logic [15:0] instr_count;

  logic [31:0] imem [0:63];
  logic        withhold;
  logic [36:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;

  exec_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_data    (imem_data),
    .rf_rs1_addr  (rf_rs1_addr),
    .rf_rs2_addr  (rf_rs2_addr),
    .ex_opcode    (ex_opcode),
    .ex_func      (ex_func),
    .ex_imm       (ex_imm),
    .ex_sonuc     (ex_sonuc),
    .ex_pc_update (ex_pc_update),
    .ex_we        (ex_we),
    .ex_hata      (ex_hata),
    .rf_we        (rf_we),
    .rf_rd_addr   (rf_rd_addr),
    .rf_wdata     (rf_wdata),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .hata         (hata),
    .instr_count  (instr_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_valid = imem_req && !withhold;
  assign imem_data  = imem[imem_addr[7:2]];

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [3:0] fn, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [5:0] imm);
    return {imm, rs2, rs1, fn, rd, op};
  endfunction

  // Scoreboard: every rf_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write got rd=%0d data=%h required no write", rf_rd_addr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_rd_addr, rf_wdata} !== e)
          $display("FAIL write_data got rd=%0d data=%h required rd=%0d data=%h",
                   rf_rd_addr, rf_wdata, e[36:32], e[31:0]);
        else pass_cnt++;
      end
    end
  end

  // Driver tasks
  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = {25'd0, OP_HALT};
  endtask

  task automatic set_model(input logic [31:0] s, input logic pcu, input logic we, input logic h);
    ex_sonuc = s; ex_pc_update = pcu; ex_we = we; ex_hata = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; withhold = 1'b0;
    set_model(32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total_cnt++;
    if (got !== req) $display("FAIL %s got %h required %h", name, got, req);
    else pass_cnt++;
  endtask

  task automatic wait_halted(input int limit);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (halted !== 1'b1) $display("FAIL wait_halted got timeout after %0d cycles required halted=1", limit);
    else pass_cnt++;
  endtask

  // Tests
  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_count", {16'd0, instr_count}, 32'd0);
    check("rst_flags", {27'd0, imem_req, rf_we, busy, halted, hata}, 32'd0);
    check("rst_ex_opcode", {25'd0, ex_opcode}, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("idle_no_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_add();
    do_reset();
    clear_imem();
    imem[0] = mk(OP_ADD, 5'd3, 4'h0, 5'd1, 5'd2, 6'b111110);
    set_model(32'd11, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({5'd3, 32'd11});
    pulse_start();
    check("add_fetch_req", {31'd0, imem_req}, 32'd1);
    check("add_fetch_addr", imem_addr, 32'h0);
    check("add_busy", {31'd0, busy}, 32'd1);
    step(2);
    check("add_ex_opcode", {25'd0, ex_opcode}, {25'd0, OP_ADD});
    check("add_rs", {22'd0, rf_rs1_addr, rf_rs2_addr}, {22'd0, 5'd1, 5'd2});
    check("add_imm_sext", ex_imm, 32'hFFFF_FFFE);
    step(1);
    check("add_we_cycle4", {31'd0, rf_we}, 32'd1);
    check("add_opcode_held", {25'd0, ex_opcode}, {25'd0, OP_ADD});
    step(1);
    check("add_pc", pc, 32'd4);
    check("add_count", {16'd0, instr_count}, 32'd1);
    check("add_we_low", {31'd0, rf_we}, 32'd0);
    step(2);
    check("add_halted", {31'd0, halted}, 32'd1);
    check("add_halt_pc", pc, 32'd4);
  endtask

  task automatic test_branch();
    do_reset();
    clear_imem();
    imem[0] = mk(OP_BR, 5'd5, 4'h1, 5'd0, 5'd0, 6'd0);
    set_model(32'h40, 1'b1, 1'b0, 1'b0);
    pulse_start();
    step(4);
    check("br_pc", pc, 32'h40);
    wait_halted(10);
    check("br_halt_pc", pc, 32'h40);
    // Restart from HALT: pc returns to RESET_PC, count retained.
    set_model(32'h40, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({5'd5, 32'h40});
    pulse_start();
    check("restart_pc", pc, 32'h0);
    check("restart_count", {16'd0, instr_count}, 32'd1);
    step(4);
    check("br_we_pc", pc, 32'h40);
    check("br_we_count", {16'd0, instr_count}, 32'd2);
    // Misaligned target.
    do_reset();
    set_model(32'h42, 1'b1, 1'b1, 1'b0);
    pulse_start();
    step(3);
    check("mis_hata", {31'd0, hata}, 32'd1);
    check("mis_pc", pc, 32'h0);
    check("mis_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_timeout();
    do_reset();
    clear_imem();
    withhold = 1'b1;
    pulse_start();
    step(14);
    check("tmo_not_yet", {30'd0, hata, imem_req}, 32'd1);
    step(1);
    check("tmo_hata", {31'd0, hata}, 32'd1);
    withhold = 1'b0;
    pulse_start();
    step(2);
    check("tmo_start_ignored", {30'd0, hata, imem_req}, 32'd2);
    do_reset();
    step(1);
    check("tmo_reset_clears", {31'd0, hata}, 32'd0);
  endtask

  task automatic test_ex_error();
    do_reset();
    clear_imem();
    imem[0] = mk(OP_ADD, 5'd3, 4'h0, 5'd1, 5'd2, 6'd0);
    set_model(32'd7, 1'b0, 1'b1, 1'b1);
    pulse_start();
    step(3);
    check("exh_hata", {31'd0, hata}, 32'd1);
    check("exh_pc", pc, 32'h0);
    step(3);
    check("exh_count", {16'd0, instr_count}, 32'd0);
  endtask

  task automatic test_rd_zero_halt();
    do_reset();
    clear_imem();
    imem[0] = mk(OP_ADD, 5'd0, 4'h2, 5'd4, 5'd5, 6'd1);
    imem[1] = mk(OP_ADD, 5'd0, 4'h3, 5'd6, 5'd7, 6'd2);
    set_model(32'd99, 1'b0, 1'b1, 1'b0);
    pulse_start();
    wait_halted(20);
    check("rd0_halt_pc", pc, 32'd8);
    check("rd0_count", {16'd0, instr_count}, 32'd2);
  endtask

  task automatic test_wrap();
    do_reset();
    clear_imem();
    imem[0]  = mk(OP_BR, 5'd1, 4'h0, 5'd0, 5'd0, 6'd0);
    imem[63] = mk(OP_NOP, 5'd1, 4'h0, 5'd0, 5'd0, 6'd0);
    set_model(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    pulse_start();
    step(4);
    check("wrap_pc_top", pc, 32'hFFFF_FFFC);
    check("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
    set_model(32'd0, 1'b0, 1'b0, 1'b0);
    step(4);
    check("wrap_pc_zero", pc, 32'h0);
    check("wrap_count", {16'd0, instr_count}, 32'd2);
  endtask

  task automatic test_reset_midflight();
    int r;
    do_reset();
    clear_imem();
    r = $urandom_range(1, 30);
    imem[0] = mk(OP_ADD, r[4:0], 4'h0, 5'd1, 5'd2, 6'd0);
    set_model(32'd77, 1'b0, 1'b1, 1'b0);
    pulse_start();
    step(2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rf_we", {31'd0, rf_we}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_ex_opcode", {25'd0, ex_opcode}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("mid_idle", {30'd0, busy, halted}, 32'd0);
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b1;
    start = 1'b0;
    withhold = 1'b0;
    clear_imem();
    set_model(32'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_branch();
    test_timeout();
    test_ex_error();
    test_rd_zero_halt();
    test_wrap();
    test_reset_midflight();
    step(2);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL pending_writes got %0d required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameters: RESET_PC, default 32'h0000_0000, first fetch address; FETCH_TIMEOUT, default 15, maximum cycles waited for imem_valid.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begins or resumes execution from IDLE or HALT.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (equals pc).
- imem_valid  in  1  imem_data valid this cycle.
- imem_data  in  32  instruction word.
- rf_rs1_addr / rf_rs2_addr  out  5 each  register file read addresses.
- ex_opcode  out  7  Execute unit opcode.
- ex_func  out  4  Execute unit func.
- ex_imm  out  32  Execute unit immediate.
- ex_sonuc  in  32  Execute unit result.
- ex_pc_update  in  1  Execute unit branch-taken flag.
- ex_we  in  1  Execute unit write-enable.
- ex_hata  in  1  Execute unit error flag.
- rf_we  out  1  register file write strobe.
- rf_rd_addr  out  5  destination register address.
- rf_wdata  out  32  write data.
- pc  out  32  program counter.
- busy  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
- halted  out  1  high in HALT.
- hata  out  1  high in ERROR.
- instr_count  out  16  count of retired instructions.

Function
REQ-003 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT, ERROR.
REQ-004 SHALL use this instruction layout: opcode=[6:0], rd=[11:7], func=[15:12], rs1=[20:16], rs2=[25:21], imm=sign-extend([31:26]).
REQ-005 SHALL handle IDLE: start=1 -> FETCH next cycle; otherwise remain in IDLE.
REQ-006 SHALL handle FETCH:
- imem_req=1 and imem_addr=pc.
- On imem_valid=1, latch imem_data into the instruction register and go to DECODE.
- The timeout counter clears on entry to FETCH.
- If imem_valid is absent for FETCH_TIMEOUT consecutive cycles -> ERROR.
REQ-007 SHALL handle DECODE:
- If opcode == HALT_OPCODE (7'b1111111) -> HALT; pc unchanged.
- Otherwise register ex_opcode, ex_func, ex_imm, rf_rs1_addr and rf_rs2_addr from the instruction register, then go to EXECUTE.
REQ-008 SHALL handle EXECUTE (one cycle): sample ex_sonuc, ex_pc_update, ex_we and ex_hata into internal registers, then:
- ex_hata=1 -> ERROR.
- ex_pc_update=1 with ex_sonuc[1:0] != 0 (misaligned target) -> ERROR.
- Otherwise -> WRITEBACK.
REQ-009 SHALL handle WRITEBACK (one cycle):
- rf_we=1 only if the latched we=1 and rd != 0; rf_rd_addr=rd; rf_wdata=latched sonuc.
- pc <= latched sonuc if the latched pc_update=1, else pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- instr_count increments, saturating at 16'hFFFF.
- Next state FETCH.
REQ-010 SHALL keep rf_we low in every state other than WRITEBACK; ERROR or HALT SHALL never produce a write.
REQ-011 SHALL handle HALT: start=1 -> FETCH with pc <= RESET_PC; instr_count retained.
REQ-012 SHALL hold ERROR until rst_n asserts; start is ignored.
REQ-013 SHALL ignore start in all states other than IDLE and HALT.
REQ-014 SHALL have a latency of 4 cycles per instruction when imem_valid answers in the first FETCH cycle; each FETCH wait cycle adds 1.
REQ-015 SHALL drive ex_* and rf_rs*_addr as registered outputs, held stable from DECODE through WRITEBACK.

Reset
REQ-016 SHALL, while rst_n=0, immediately force:
- state IDLE, pc=RESET_PC, instr_count=0.
- imem_req=0, rf_we=0, busy=0, halted=0, hata=0.
- ex_opcode=0, ex_func=0, ex_imm=0, rf_*_addr=0, rf_wdata=0.
REQ-017 SHALL abandon any in-flight instruction on reset mid-operation; no write strobe SHALL be issued after reset asserts.

Structure
REQ-018 SHALL place the state enum, HALT_OPCODE and the field bit positions in package exec_seq_pkg.
REQ-019 SHALL put field extraction and sign extension in sub-module exec_seq_decode (combinational); the FSM, timeout counter and registers live in exec_sequencer.

Verification
REQ-020 SHALL cover these directed scenarios:
- Reset, then start; imem_valid immediate with ADD rd=3 and Execute model returning sonuc=11, we=1 -> rf_we pulse at cycle 4, rf_rd_addr=3, rf_wdata=11, pc=4, instr_count=1.
- Branch: ex_pc_update=1, sonuc=32'h40 -> pc=32'h40, rf_we=0 unless we=1; misaligned sonuc=32'h42 -> hata=1, pc unchanged.
- imem_valid withheld 15 cycles -> ERROR, hata=1; start ignored; rst_n low clears it.
- ex_hata=1 in EXECUTE -> ERROR, no rf_we; a write with rd=0 and we=1 -> no rf_we, pc advances.
- HALT opcode at pc=8 -> halted=1, pc=8; start -> pc=RESET_PC, FETCH resumes; pc=32'hFFFF_FFFC sequential -> pc=0.
